// File: rtl/iph_step_sched.sv
// Per-timestep scheduler for the Iph photocurrent calculator: reads N_CH samples, issues one
// calculation per cycle and writes results back in issue order. Optional feature: IPH_NEG_CLAMP_EN.
module iph_step_sched #(
    parameter int SINGLE  = 32,
    parameter int N_CH    = 8,
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_sta,
    output logic              busy,
    output logic              step_done,
    output logic              rd_en,
    output logic [IDX_W-1:0]  rd_idx,
    input  logic [SINGLE-1:0] S_in,
    input  logic [SINGLE-1:0] T_in,
    output logic              calc_sta,
    output logic [SINGLE-1:0] calc_S,
    output logic [SINGLE-1:0] calc_T,
    input  logic              calc_done,
    input  logic [SINGLE-1:0] calc_Iph,
    output logic              iph_wr_en,
    output logic [IDX_W-1:0]  iph_wr_addr,
    output logic [SINGLE-1:0] iph_wr_data,
    output logic [1:0]        err
`ifdef IPH_NEG_CLAMP_EN
    ,
    output logic [7:0]        clamp_cnt
`endif
);

    localparam int OUT_W = IDX_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_CH - 1);
    localparam logic [OUT_W-1:0]  LAST_WR  = OUT_W'(N_CH - 1);
    localparam logic [OUT_W-1:0]  OUT_ZERO = {OUT_W{1'b0}};
    localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0]   WD_ZERO  = {WD_W{1'b0}};
    localparam logic [SINGLE-1:0] DATA_ZERO = {SINGLE{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [IDX_W-1:0]  idx_r;
    logic              rd_en_r;
    logic              calc_sta_r;
    logic              busy_r;
    logic              step_done_r;
    logic [OUT_W-1:0]  out_r;
    logic [WD_W-1:0]   wd_r;
    logic [WD_W-1:0]   wd_s;
    logic [OUT_W-1:0]  wr_cnt_r;
    logic              wr_en_r;
    logic [IDX_W-1:0]  wr_addr_r;
    logic [SINGLE-1:0] wr_data_r;
    logic [1:0]        err_r;
    logic              res_vld_s;
    logic              spur_s;
    logic              run_s;
    logic              accept_s;
    logic              timeout_s;
    logic              wr_s;
    logic              last_wr_s;
    logic              neg_s;
    logic [SINGLE-1:0] data_s;

`ifdef IPH_NEG_CLAMP_EN
    assign neg_s = calc_Iph[SINGLE-1];
`else
    assign neg_s = 1'b0;
`endif

    // Result qualification, watchdog next value and write-data selection
    always_comb begin
        res_vld_s = calc_done && (out_r != OUT_ZERO);
        spur_s    = calc_done && (out_r == OUT_ZERO);
        run_s     = (state_r == ST_ISSUE) || (state_r == ST_DRAIN);
        accept_s  = (state_r == ST_IDLE) && step_sta;
        wr_s      = res_vld_s && run_s;
        last_wr_s = wr_s && (wr_cnt_r == LAST_WR);
        if (calc_done || (out_r == OUT_ZERO)) begin
            wd_s = WD_ZERO;
        end else if (wd_r == WD_MAX) begin
            wd_s = wd_r;
        end else begin
            wd_s = wd_r + WD_W'(1'b1);
        end
        timeout_s = (wd_s == WD_MAX);
        if (neg_s) begin
            data_s = DATA_ZERO;
        end else begin
            data_s = calc_Iph;
        end
    end

    // Next-state logic; completion beats timeout since a result clears the watchdog
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (step_sta) state_s = ST_ISSUE;
                else          state_s = ST_IDLE;
            end
            ST_ISSUE: begin
                if (last_wr_s)              state_s = ST_DONE;
                else if (timeout_s)         state_s = ST_ERR;
                else if (idx_r == LAST_IDX) state_s = ST_DRAIN;
                else                        state_s = ST_ISSUE;
            end
            ST_DRAIN: begin
                if (last_wr_s)      state_s = ST_DONE;
                else if (timeout_s) state_s = ST_ERR;
                else                state_s = ST_DRAIN;
            end
            ST_DONE: state_s = ST_IDLE;
            ST_ERR:  state_s = ST_ERR;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and registered control outputs derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= {IDX_W{1'b0}};
            rd_en_r     <= 1'b0;
            calc_sta_r  <= 1'b0;
            busy_r      <= 1'b0;
            step_done_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if ((state_r == ST_ISSUE) && (state_s == ST_ISSUE)) idx_r <= idx_r + IDX_W'(1'b1);
            else                                                idx_r <= {IDX_W{1'b0}};
            rd_en_r     <= (state_s == ST_ISSUE);
            calc_sta_r  <= rd_en_r;
            busy_r      <= (state_s == ST_ISSUE) || (state_s == ST_DRAIN) || (state_s == ST_DONE);
            step_done_r <= (state_s == ST_DONE);
        end
    end

    // Outstanding-work counter, watchdog and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r <= OUT_ZERO;
            wd_r  <= WD_ZERO;
            err_r <= 2'b00;
        end else begin
            out_r    <= out_r + {{IDX_W{1'b0}}, calc_sta_r} - {{IDX_W{1'b0}}, res_vld_s};
            wd_r     <= wd_s;
            err_r[0] <= err_r[0] | ((state_s == ST_ERR) && (state_r != ST_ERR));
            err_r[1] <= err_r[1] | spur_s;
        end
    end

    // Result RAM write port; addresses follow result arrival order
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_r  <= OUT_ZERO;
            wr_en_r   <= 1'b0;
            wr_addr_r <= {IDX_W{1'b0}};
            wr_data_r <= DATA_ZERO;
        end else begin
            wr_en_r <= wr_s;
            if (accept_s) begin
                wr_cnt_r <= OUT_ZERO;
            end else if (wr_s) begin
                wr_cnt_r <= wr_cnt_r + OUT_W'(1'b1);
            end else begin
                wr_cnt_r <= wr_cnt_r;
            end
            if (wr_s) begin
                wr_addr_r <= wr_cnt_r[IDX_W-1:0];
                wr_data_r <= data_s;
            end else begin
                wr_addr_r <= wr_addr_r;
                wr_data_r <= wr_data_r;
            end
        end
    end

`ifdef IPH_NEG_CLAMP_EN
    logic [7:0] clamp_cnt_r;

    // Saturating count of negative results forced to zero in the current step
    always_ff @(posedge clk) begin
        if (rst) begin
            clamp_cnt_r <= 8'd0;
        end else if (accept_s) begin
            clamp_cnt_r <= 8'd0;
        end else if (wr_s && neg_s && (clamp_cnt_r != 8'd255)) begin
            clamp_cnt_r <= clamp_cnt_r + 8'd1;
        end else begin
            clamp_cnt_r <= clamp_cnt_r;
        end
    end

    assign clamp_cnt = clamp_cnt_r;
`endif

    assign busy        = busy_r;
    assign step_done   = step_done_r;
    assign rd_en       = rd_en_r;
    assign rd_idx      = idx_r;
    assign calc_sta    = calc_sta_r;
    assign calc_S      = S_in;
    assign calc_T      = T_in;
    assign iph_wr_en   = wr_en_r;
    assign iph_wr_addr = wr_addr_r;
    assign iph_wr_data = wr_data_r;
    assign err         = err_r;

endmodule

// File: tb/tb_iph_step_sched.sv
// Bench for iph_step_sched: transaction-level reference model, calculator BFM with fixed
// latency, directed scenarios with literal expectations followed by randomized steps.
`timescale 1ns/1ps
module tb_iph_step_sched;
    localparam int N_CH    = 8;
    localparam int IDX_W   = 3;
    localparam int TIMEOUT = 64;
`ifdef IPH_NEG_CLAMP_EN
    localparam logic [31:0] CLAMP_EXP = 32'h0000_0000;
`else
    localparam logic [31:0] CLAMP_EXP = 32'hBF80_0000;
`endif

    logic clk = 1'b0;
    logic rst, step_sta, calc_done;
    logic [31:0] S_in, T_in, calc_Iph;
    logic busy, step_done, rd_en, calc_sta, iph_wr_en;
    logic [IDX_W-1:0] rd_idx, iph_wr_addr;
    logic [31:0] calc_S, calc_T, iph_wr_data;
    logic [1:0] err;
`ifdef IPH_NEG_CLAMP_EN
    logic [7:0] clamp_cnt;
`endif

    iph_step_sched #(.SINGLE(32), .N_CH(N_CH), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .step_sta(step_sta), .busy(busy), .step_done(step_done),
        .rd_en(rd_en), .rd_idx(rd_idx), .S_in(S_in), .T_in(T_in), .calc_sta(calc_sta),
        .calc_S(calc_S), .calc_T(calc_T), .calc_done(calc_done), .calc_Iph(calc_Iph),
        .iph_wr_en(iph_wr_en), .iph_wr_addr(iph_wr_addr), .iph_wr_data(iph_wr_data),
        .err(err)
`ifdef IPH_NEG_CLAMP_EN
        , .clamp_cnt(clamp_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    // reference model state: phase 0 idle, 1 running, 2 done cycle, 3 error
    int ph = 0, t = 0, outs = 0, wd = 0, wr = 0, clamp_c = 0, iss_ch = 0;
    logic [1:0] merr = 2'b00;
    bit e_rd_en = 1'b0, e_calc_sta = 1'b0, e_busy = 1'b0, e_step_done = 1'b0, e_wr_en = 1'b0;
    int e_rd_idx = 0, e_wr_addr = 0, e_clamp = 0;
    logic [31:0] e_wr_data = 32'h0;

    // calculator BFM
    typedef struct { int t; logic [31:0] d; } item_t;
    item_t pq[$];
    int lat = 19;
    bit drop_ch2 = 1'b0;
    bit force_neg = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_update();
        bit vld, spr, sta_prev, rd_prev;
        int nwd;
        sta_prev = e_calc_sta;
        rd_prev  = e_rd_en;
        e_wr_en = 1'b0;
        e_step_done = 1'b0;
        if (rst) begin
            ph = 0; t = 0; outs = 0; wd = 0; wr = 0; clamp_c = 0; iss_ch = 0; merr = 2'b00;
            e_calc_sta = 1'b0; e_rd_en = 1'b0; e_rd_idx = 0; e_busy = 1'b0; e_clamp = 0;
        end else begin
            vld = calc_done && (outs > 0);
            spr = calc_done && (outs == 0);
            if (calc_done || outs == 0) nwd = 0;
            else nwd = (wd < TIMEOUT) ? wd + 1 : TIMEOUT;
            case (ph)
                0: if (step_sta) begin ph = 1; t = 1; wr = 0; clamp_c = 0; iss_ch = 0; end
                1: begin
                    if (vld) begin
                        e_wr_en = 1'b1; e_wr_addr = wr; e_wr_data = calc_Iph;
`ifdef IPH_NEG_CLAMP_EN
                        if (calc_Iph[31]) begin
                            e_wr_data = 32'h0;
                            if (clamp_c < 255) clamp_c++;
                        end
`endif
                        wr++;
                        if (wr == N_CH) begin ph = 2; e_step_done = 1'b1; end
                        else t++;
                    end else if (nwd >= TIMEOUT) begin
                        ph = 3; merr[0] = 1'b1;
                    end else begin
                        t++;
                    end
                end
                2: ph = 0;
                default: ;
            endcase
            if (spr) merr[1] = 1'b1;
            outs = outs + int'(sta_prev) - int'(vld);
            wd = nwd;
            e_calc_sta = rd_prev;
            e_rd_en = (ph == 1) && (t <= N_CH);
            e_rd_idx = e_rd_en ? t - 1 : 0;
            e_busy = (ph == 1) || (ph == 2);
            e_clamp = clamp_c;
        end
    endtask

    // advance one cycle: update model at the edge, then drive this cycle's inputs
    task automatic tick(input bit r, input bit s, input bit spur);
        item_t it;
        logic [31:0] d;
        @(posedge clk);
        model_update();
        cyc++;
        if (e_calc_sta) begin
            d = $urandom;
            if (force_neg && iss_ch == 2) d = 32'hBF80_0000;
            else if (force_neg) d[31] = 1'b0;
            if (!(drop_ch2 && iss_ch == 2)) begin
                it.t = cyc + lat; it.d = d; pq.push_back(it);
            end
            iss_ch++;
        end
        #1;
        rst = r; step_sta = s; S_in = $urandom; T_in = $urandom;
        calc_done = 1'b0; calc_Iph = $urandom;
        if (r) begin
            pq.delete();
        end else if (pq.size() > 0 && pq[0].t == cyc) begin
            it = pq.pop_front(); calc_done = 1'b1; calc_Iph = it.d;
        end else if (spur) begin
            calc_done = 1'b1;
        end
        #1;
    endtask

    // compare DUT outputs against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_en", rd_en, e_rd_en);
            chk("rd_idx", rd_idx, e_rd_idx);
            chk("calc_sta", calc_sta, e_calc_sta);
            chk("calc_S", calc_S, S_in);
            chk("calc_T", calc_T, T_in);
            chk("busy", busy, e_busy);
            chk("step_done", step_done, e_step_done);
            chk("iph_wr_en", iph_wr_en, e_wr_en);
            chk("err", err, merr);
            if (e_wr_en) begin
                chk("iph_wr_addr", iph_wr_addr, e_wr_addr);
                chk("iph_wr_data", iph_wr_data, e_wr_data);
            end
`ifdef IPH_NEG_CLAMP_EN
            chk("clamp_cnt", clamp_cnt, e_clamp);
`endif
        end
    end

    initial begin
        int rst_at;
        bit fin;
        rst = 1'b1; step_sta = 1'b0; calc_done = 1'b0; calc_Iph = 32'h0; S_in = 32'h0; T_in = 32'h0;
        tick(1'b1, 1'b0, 1'b0);
        chk_en = 1'b1;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("reset_busy", busy, 32'd0);
        chk("reset_err", err, 32'd0);

        // nominal step, ignored request while busy, back-to-back step after step_done
        tick(1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 60; k++) begin
            tick(1'b0, (k == 5) || (k == 30), 1'b0);
            if (k == 1)  begin chk("s1_rd_en", rd_en, 32'd1); chk("s1_rd_idx0", rd_idx, 32'd0); end
            if (k == 2)  chk("s1_calc_sta", calc_sta, 32'd1);
            if (k == 8)  chk("s1_rd_idx7", rd_idx, 32'd7);
            if (k == 9)  chk("s1_rd_en_off", rd_en, 32'd0);
            if (k == 22) begin chk("s1_wr0_en", iph_wr_en, 32'd1); chk("s1_wr0_addr", iph_wr_addr, 32'd0); end
            if (k == 24) begin chk("s1_wr2_addr", iph_wr_addr, 32'd2); chk("s1_wr2_data", iph_wr_data, CLAMP_EXP); end
            if (k == 29) begin
                chk("s1_step_done", step_done, 32'd1); chk("s1_wr7_addr", iph_wr_addr, 32'd7);
`ifdef IPH_NEG_CLAMP_EN
                chk("s1_clamp_cnt", clamp_cnt, 32'd1);
`endif
            end
            if (k == 30) begin chk("s1_done_low", step_done, 32'd0); chk("s1_idle", busy, 32'd0); end
            if (k == 31) chk("s2_rd_en", rd_en, 32'd1);
            if (k == 59) chk("s2_step_done", step_done, 32'd1);
        end

        // reset mid-step
        tick(1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            tick(k == 12, 1'b0, 1'b0);
            if (k == 13) begin
                chk("rst_busy", busy, 32'd0); chk("rst_err", err, 32'd0);
                chk("rst_wr_en", iph_wr_en, 32'd0); chk("rst_calc_sta", calc_sta, 32'd0);
            end
        end

        // spurious calc_done while idle, then a normal step with latency 7
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        chk("spur_wr_en", iph_wr_en, 32'd0);
        chk("spur_err", err, 32'd2);
        lat = 7;
        tick(1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            if (k == 17) chk("spur_step_done", step_done, 32'd1);
        end

        // dropped third result leads to watchdog timeout
        tick(1'b1, 1'b0, 1'b0);
        lat = 19; drop_ch2 = 1'b1;
        tick(1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 110; k++) begin
            tick(1'b0, k == 100, 1'b0);
            if (k == 92) chk("to_not_yet", err, 32'd0);
            if (k == 93) begin chk("to_err", err, 32'd1); chk("to_busy", busy, 32'd0); end
            if (k == 101) chk("to_held", busy, 32'd0);
        end
        tick(1'b1, 1'b0, 1'b0);
        drop_ch2 = 1'b0;

        // randomized steps
        force_neg = 1'b0;
        for (int it = 0; it < 25; it++) begin
            lat = $urandom_range(1, 40);
            drop_ch2 = ($urandom_range(0, 7) == 0);
            rst_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 30)) : -1;
            if ($urandom_range(0, 2) == 0) tick(1'b0, 1'b0, 1'b1);
            tick(1'b0, 1'b1, 1'b0);
            fin = 1'b0;
            for (int k = 1; k <= 200 && !fin; k++) begin
                tick(k == rst_at, (ph != 0) && ($urandom_range(0, 3) == 0), 1'b0);
                if (ph == 3) begin
                    repeat (5) tick(1'b0, 1'b0, 1'b0);
                    tick(1'b1, 1'b0, 1'b0);
                    fin = 1'b1;
                end else if (ph == 0 && pq.size() == 0) begin
                    fin = 1'b1;
                end
            end
            chk("step_bound", fin, 32'd1);
            drop_ch2 = 1'b0;
        end

        repeat (3) tick(1'b0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
